// File: rtl/edge_event_arbiter.sv
// rtl/edge_event_arbiter.sv - rising-edge event capture with round-robin single-slot output
// Optional sticky overflow tracking is enabled by defining EDGE_ARB_OVF_EN.
module edge_event_arbiter #(
    parameter  int NCH = 4,
    localparam int IDW = (NCH > 2) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] level,
    output logic           ev_valid,
    output logic [IDW-1:0] ev_id,
    input  logic           ev_ready,
    output logic [NCH-1:0] pend,
    output logic [NCH-1:0] ovf,
    input  logic           ovf_clr
);

    logic [NCH-1:0] prev_q;
    logic [NCH-1:0] pend_q, pend_d;
    logic           ev_valid_q, ev_valid_d;
    logic [IDW-1:0] ev_id_q, ev_id_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [NCH-1:0] rise;
    logic [NCH-1:0] load_mask;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] cand;
    logic           found;
    logic           slot_free;
    logic           load;

    // (base + k) mod NCH without a divider; both operands are below NCH
    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NCH) begin
            s = s - NCH;
        end
        return IDW'(s);
    endfunction

    assign rise      = level & ~prev_q;
    assign slot_free = !ev_valid_q || ev_ready;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < NCH; k++) begin
            cand = rr_idx(ptr_q, k);
            if (!found && pend_q[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign load      = slot_free && found;
    assign load_mask = load ? (NCH'(1) << winner) : '0;

    always_comb begin
        pend_d     = (pend_q & ~load_mask) | rise;
        ev_valid_d = slot_free ? found : ev_valid_q;
        ev_id_d    = load ? winner : ev_id_q;
        ptr_d      = ptr_q;
        if (load) begin
            ptr_d = (winner == IDW'(NCH - 1)) ? '0 : winner + 1'b1;
        end
    end

    // prev tracks level even in reset so a level held through reset is not an edge
    always_ff @(posedge clk) begin
        prev_q <= level;
        if (rst) begin
            pend_q     <= '0;
            ev_valid_q <= 1'b0;
            ev_id_q    <= '0;
            ptr_q      <= '0;
        end else begin
            pend_q     <= pend_d;
            ev_valid_q <= ev_valid_d;
            ev_id_q    <= ev_id_d;
            ptr_q      <= ptr_d;
        end
    end

    assign ev_valid = ev_valid_q;
    assign ev_id    = ev_id_q;
    assign pend     = pend_q;

`ifdef EDGE_ARB_OVF_EN
    logic [NCH-1:0] ovf_q, ovf_d;

    // a rise on a channel that stays pending is merged and flagged
    always_comb begin
        ovf_d = ovf_q | (rise & pend_q & ~load_mask);
        if (ovf_clr) begin
            ovf_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign ovf            = '0;
`endif

endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb/tb_edge_event_arbiter.sv - scoreboard bench for edge_event_arbiter
module tb_edge_event_arbiter;

    localparam int NCH = 4;
    localparam int IDW = 2;
`ifdef EDGE_ARB_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NCH-1:0] level = '0;
    logic           ev_valid;
    logic [IDW-1:0] ev_id;
    logic           ev_ready = 1'b0;
    logic [NCH-1:0] pend;
    logic [NCH-1:0] ovf;
    logic           ovf_clr = 1'b0;

    edge_event_arbiter #(.NCH(NCH)) dut (
        .clk      (clk),
        .rst      (rst),
        .level    (level),
        .ev_valid (ev_valid),
        .ev_id    (ev_id),
        .ev_ready (ev_ready),
        .pend     (pend),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           valid;
        int           id;
        bit [NCH-1:0] pend;
        bit [NCH-1:0] ovf;
    } snap_t;

    snap_t exp_state_q[$];
    int    exp_xfer_q[$];
    int    errors = 0;
    int    checks = 0;
    bit    done   = 1'b0;

    // reference model: event sets, a one-entry slot and a rotating priority start
    bit m_pend[NCH];
    bit m_ovf[NCH];
    bit m_prev[NCH];
    int m_slot = -1;
    int m_id   = 0;
    int m_ptr  = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit [NCH-1:0] lv, input bit rdy, input bit clr = 1'b0,
                        input bit rs = 1'b0);
        snap_t s;
        int    loaded;
        level    = lv;
        ev_ready = rdy;
        ovf_clr  = clr;
        rst      = rs;
        if (m_slot >= 0 && rdy) exp_xfer_q.push_back(m_slot);
        if (rs) begin
            for (int i = 0; i < NCH; i++) begin
                m_pend[i] = 1'b0;
                m_ovf[i]  = 1'b0;
            end
            m_slot = -1;
            m_id   = 0;
            m_ptr  = 0;
        end else begin
            loaded = -1;
            if (m_slot < 0 || rdy) begin
                m_slot = -1;
                for (int k = 0; k < NCH; k++) begin
                    if (loaded < 0 && m_pend[(m_ptr + k) % NCH]) loaded = (m_ptr + k) % NCH;
                end
                if (loaded >= 0) begin
                    m_slot         = loaded;
                    m_id           = loaded;
                    m_pend[loaded] = 1'b0;
                    m_ptr          = (loaded + 1) % NCH;
                end
            end
            for (int i = 0; i < NCH; i++) begin
                if (lv[i] && !m_prev[i]) begin
                    if (m_pend[i] && OVF_EN) m_ovf[i] = 1'b1;
                    m_pend[i] = 1'b1;
                end
            end
            if (clr) begin
                for (int i = 0; i < NCH; i++) m_ovf[i] = 1'b0;
            end
        end
        for (int i = 0; i < NCH; i++) m_prev[i] = lv[i];
        s.valid = (m_slot >= 0);
        s.id    = m_id;
        for (int i = 0; i < NCH; i++) begin
            s.pend[i] = m_pend[i];
            s.ovf[i]  = m_ovf[i];
        end
        exp_state_q.push_back(s);
        @(posedge clk);
        #1;
    endtask

    // monitor: outputs settled after each edge, handshake decided for the next one
    initial begin
        snap_t s;
        forever begin
            @(negedge clk);
            if (done) break;
            if (exp_state_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL state_underflow actual=empty required=entry at %0t", $time);
            end else begin
                s = exp_state_q.pop_front();
                check("ev_valid", int'(ev_valid), int'(s.valid));
                check("ev_id", int'(ev_id), s.id);
                check("pend", int'(pend), int'(s.pend));
                check("ovf", int'(ovf), int'(s.ovf));
            end
            if (ev_valid && ev_ready) begin
                if (exp_xfer_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL xfer_unexpected actual=id%0d required=none at %0t",
                             ev_id, $time);
                end else begin
                    check("xfer_id", int'(ev_id), exp_xfer_q.pop_front());
                end
            end
        end
    end

    initial begin
        bit [NCH-1:0] lv;
        step(4'b0000, 1'b0, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b0, 1'b1);

        // single edge
        step(4'b0001, 1'b1);
        repeat (4) step(4'b0000, 1'b1);

        // simultaneous edges on all channels
        repeat (6) step(4'b1111, 1'b1);
        repeat (2) step(4'b0000, 1'b1);

        // fairness: grant ch1, then rises on 0,1,3
        step(4'b0010, 1'b1);
        repeat (3) step(4'b0000, 1'b1);
        step(4'b1011, 1'b1);
        repeat (5) step(4'b0000, 1'b1);

        // backpressure with repeated ch2 pulses, then release and clear
        step(4'b0100, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b0100, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b0100, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b0100, 1'b0);
        repeat (2) step(4'b0000, 1'b0);
        repeat (4) step(4'b0000, 1'b1);
        step(4'b0000, 1'b1, 1'b1);
        step(4'b0000, 1'b1);

        // rise on ch1 at the same edge ch1 is loaded
        step(4'b0001, 1'b0);
        step(4'b0011, 1'b0);
        step(4'b0001, 1'b0);
        step(4'b0011, 1'b1);
        repeat (4) step(4'b0001, 1'b1);
        repeat (2) step(4'b0000, 1'b1);

        // reset mid-operation with levels held high
        step(4'b1010, 1'b0);
        step(4'b1010, 1'b0);
        repeat (2) step(4'b1010, 1'b0, 1'b0, 1'b1);
        repeat (4) step(4'b1010, 1'b1);
        repeat (2) step(4'b0000, 1'b1);

        // randomized traffic
        lv = '0;
        for (int n = 0; n < 1500; n++) begin
            lv = lv ^ NCH'($urandom & $urandom);
            step(lv, $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
                 $urandom_range(0, 199) == 0);
        end

        repeat (3) step(4'b0000, 1'b0);
        @(negedge clk);
        #1;
        done = 1'b1;
        check("xfer_queue_drained", exp_xfer_q.size(), 0);
        check("state_queue_drained", exp_state_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
